// File: rtl/pipe_ctrl.sv
// Pipeline control: builds the stall vector and the flush/jump redirects, latches
// interrupts until a clean RUN boundary, and sequences debug halt entry, drain and resume.
`ifndef STALL_WIDTH
`define STALL_WIDTH 4
`endif
`ifndef STALL_PC
`define STALL_PC 0
`define STALL_IF 1
`define STALL_ID 2
`define STALL_EX 3
`endif

module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    jump_req_i,
  input  logic [31:0]             jump_addr_i,
  input  logic                    ex_hold_req_i,
  input  logic                    int_req_i,
  input  logic [31:0]             int_addr_i,
  input  logic [31:0]             resume_pc_i,
  input  logic                    dbg_halt_req_i,
  input  logic                    dbg_resume_req_i,
  output logic [`STALL_WIDTH-1:0] stall_o,
  output logic                    flush_o,
  output logic                    jump_o,
  output logic [31:0]             jump_addr_o,
  output logic                    int_ack_o,
  output logic                    dbg_halted_o
);

  typedef enum logic [1:0] {RUN, HALT_WAIT, DRAIN, HALTED} state_t;

  localparam logic [`STALL_WIDTH-1:0] STALL_ALL = '1;
  localparam logic [`STALL_WIDTH-1:0] STALL_PC_ONLY = `STALL_WIDTH'(1) << `STALL_PC;

  state_t      state_q, state_d;
  logic        int_pend_q;
  logic [31:0] int_addr_q;
  logic        halt_pend_q;
  logic [31:0] resume_pc_q;
  logic [3:0]  drain_cnt_q;
  logic        dbg_halted_q;

  logic                    int_take;
  logic                    halt_enter;
  logic [`STALL_WIDTH-1:0] stall_c;
  logic                    flush_c;
  logic                    jump_c;
  logic [31:0]             jump_addr_c;
  logic                    int_ack_c;

  always_comb begin
    state_d     = state_q;
    stall_c     = '0;
    flush_c     = 1'b0;
    jump_c      = 1'b0;
    jump_addr_c = 32'h0;
    int_ack_c   = 1'b0;
    int_take    = 1'b0;
    halt_enter  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (jump_req_i) begin
          flush_c     = 1'b1;
          jump_c      = 1'b1;
          jump_addr_c = jump_addr_i;
        end else if (ex_hold_req_i) begin
          stall_c = STALL_ALL;
        end else if (halt_pend_q) begin
          state_d = HALT_WAIT;
        end else if (int_pend_q) begin
          flush_c     = 1'b1;
          jump_c      = 1'b1;
          jump_addr_c = int_addr_q;
          int_ack_c   = 1'b1;
          int_take    = 1'b1;
        end
      end
      HALT_WAIT: begin
        if (jump_req_i) begin
          flush_c     = 1'b1;
          jump_c      = 1'b1;
          jump_addr_c = jump_addr_i;
        end else if (ex_hold_req_i) begin
          stall_c = STALL_ALL;
        end else begin
          // Refetch from the oldest un-executed PC; the jump overrides the PC stall.
          flush_c     = 1'b1;
          jump_c      = 1'b1;
          jump_addr_c = resume_pc_i;
          stall_c     = STALL_PC_ONLY;
          halt_enter  = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        stall_c = STALL_ALL;
        if (drain_cnt_q == 4'd1) state_d = HALTED;
      end
      HALTED: begin
        stall_c = STALL_ALL;
        if (dbg_resume_req_i) begin
          flush_c     = 1'b1;
          jump_c      = 1'b1;
          jump_addr_c = resume_pc_q;
          stall_c     = '0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      int_pend_q   <= 1'b0;
      int_addr_q   <= 32'h0;
      halt_pend_q  <= 1'b0;
      resume_pc_q  <= 32'h0;
      drain_cnt_q  <= 4'd0;
      dbg_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dbg_halted_q <= (state_d == HALTED);
      // A request arriving in the take cycle re-arms the pending flag.
      if (int_req_i) begin
        int_pend_q <= 1'b1;
        int_addr_q <= int_addr_i;
      end else if (int_take) begin
        int_pend_q <= 1'b0;
      end
      if (halt_enter) begin
        halt_pend_q <= 1'b0;
      end else if (dbg_halt_req_i && state_q == RUN) begin
        halt_pend_q <= 1'b1;
      end
      if (halt_enter) resume_pc_q <= resume_pc_i;
      if (halt_enter) begin
        drain_cnt_q <= 4'(DRAIN_CYCLES);
      end else if (state_q == DRAIN) begin
        drain_cnt_q <= drain_cnt_q - 4'd1;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall_o      = rst_n ? stall_c     : '0;
  assign flush_o      = rst_n ? flush_c     : 1'b0;
  assign jump_o       = rst_n ? jump_c      : 1'b0;
  assign jump_addr_o  = rst_n ? jump_addr_c : 32'h0;
  assign int_ack_o    = rst_n ? int_ack_c   : 1'b0;
  assign dbg_halted_o = dbg_halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all checked
// against a cycle model built from the halt/interrupt/redirect rules.
module tb_pipe_ctrl;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        ex_hold_req_i = 1'b0;
  logic        int_req_i = 1'b0;
  logic [31:0] int_addr_i = 32'h0;
  logic [31:0] resume_pc_i = 32'h0;
  logic        dbg_halt_req_i = 1'b0;
  logic        dbg_resume_req_i = 1'b0;
  logic [3:0]  stall_o;
  logic        flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        int_ack_o;
  logic        dbg_halted_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .ex_hold_req_i(ex_hold_req_i),
    .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .resume_pc_i(resume_pc_i),
    .dbg_halt_req_i(dbg_halt_req_i), .dbg_resume_req_i(dbg_resume_req_i),
    .stall_o(stall_o), .flush_o(flush_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .int_ack_o(int_ack_o), .dbg_halted_o(dbg_halted_o)
  );

  int total = 0;
  int bad = 0;

  // Model: halt progress is tracked as "waiting for a clean flush", "drain cycles
  // left" and "halted"; none of these set means the core is running.
  bit          m_int_pend, m_halt_pend, m_wait, m_halted;
  logic [31:0] m_int_addr, m_saved;
  int          m_drain;
  bit          n_int_pend, n_halt_pend, n_wait, n_halted;
  logic [31:0] n_int_addr, n_saved;
  int          n_drain;

  logic [3:0]  e_stall;
  logic        e_flush, e_jump, e_ack, e_halted;
  logic [31:0] e_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_int_pend = 0; m_halt_pend = 0; m_wait = 0; m_halted = 0;
    m_int_addr = '0; m_saved = '0; m_drain = 0;
  endtask

  task automatic redirect(input logic [31:0] a);
    e_flush = 1'b1; e_jump = 1'b1; e_addr = a;
  endtask

  task automatic model_eval();
    bit taken, running;
    n_int_pend = m_int_pend; n_halt_pend = m_halt_pend; n_wait = m_wait;
    n_halted = m_halted; n_int_addr = m_int_addr; n_saved = m_saved; n_drain = m_drain;
    e_stall = 4'h0; e_flush = 0; e_jump = 0; e_addr = 32'h0; e_ack = 0;
    e_halted = m_halted;
    taken = 0;
    running = !m_halted && m_drain == 0 && !m_wait;
    if (m_halted) begin
      e_stall = 4'hF;
      if (dbg_resume_req_i) begin
        redirect(m_saved);
        e_stall = 4'h0;
        n_halted = 0;
      end
    end else if (m_drain > 0) begin
      e_stall = 4'hF;
      n_drain = m_drain - 1;
      if (m_drain == 1) n_halted = 1;
    end else if (m_wait) begin
      if (jump_req_i) redirect(jump_addr_i);
      else if (ex_hold_req_i) e_stall = 4'hF;
      else begin
        redirect(resume_pc_i);
        e_stall = 4'b0001;
        n_saved = resume_pc_i;
        n_wait = 0;
        n_halt_pend = 0;
        n_drain = DC;
      end
    end else begin
      if (jump_req_i) redirect(jump_addr_i);
      else if (ex_hold_req_i) e_stall = 4'hF;
      else if (m_halt_pend) n_wait = 1;
      else if (m_int_pend) begin
        redirect(m_int_addr);
        e_ack = 1;
        taken = 1;
      end
    end
    if (dbg_halt_req_i && running) n_halt_pend = 1;
    if (int_req_i) begin
      n_int_pend = 1;
      n_int_addr = int_addr_i;
    end else if (taken) begin
      n_int_pend = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("stall", {28'h0, stall_o}, {28'h0, e_stall});
    chk("flush", {31'h0, flush_o}, {31'h0, e_flush});
    chk("jump", {31'h0, jump_o}, {31'h0, e_jump});
    chk("jump_addr", jump_addr_o, e_addr);
    chk("int_ack", {31'h0, int_ack_o}, {31'h0, e_ack});
    chk("halted", {31'h0, dbg_halted_o}, {31'h0, e_halted});
  endtask

  task automatic adv();
    @(posedge clk);
    m_int_pend = n_int_pend; m_halt_pend = n_halt_pend; m_wait = n_wait;
    m_halted = n_halted; m_int_addr = n_int_addr; m_saved = n_saved; m_drain = n_drain;
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic clear_inputs();
    jump_req_i = 0; ex_hold_req_i = 0; int_req_i = 0;
    dbg_halt_req_i = 0; dbg_resume_req_i = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {28'h0, stall_o}, 32'h0);
    chk({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
    chk({tag, "_jump"}, {31'h0, jump_o}, 32'h0);
    chk({tag, "_addr"}, jump_addr_o, 32'h0);
    chk({tag, "_ack"}, {31'h0, int_ack_o}, 32'h0);
    chk({tag, "_halted"}, {31'h0, dbg_halted_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int hold_left;
    bit seen;
    model_reset();

    // Reset holds every output low even with requests active.
    #2;
    jump_req_i = 1; jump_addr_i = 32'hABCD_0000; ex_hold_req_i = 1;
    int_req_i = 1; int_addr_i = 32'h1234_5678; dbg_halt_req_i = 1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1;
    repeat (2) tick();

    // Idle jump.
    jump_req_i = 1; jump_addr_i = 32'h0000_0100;
    settle();
    chk("jump100_addr", jump_addr_o, 32'h100);
    chk("jump100_stall", {28'h0, stall_o}, 32'h0);
    adv();
    clear_inputs();
    tick();

    // Five-cycle hold; a jump in its last cycle wins.
    ex_hold_req_i = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin jump_req_i = 1; jump_addr_i = 32'h200; end
      settle();
      chk("hold_stall", {28'h0, stall_o}, (i == 4) ? 32'h0 : 32'hF);
      chk("hold_flush", {31'h0, flush_o}, (i == 4) ? 32'h1 : 32'h0);
      adv();
    end
    clear_inputs();
    tick();

    // Interrupt during a three-cycle hold is taken once, right after the hold.
    ex_hold_req_i = 1; int_req_i = 1; int_addr_i = 32'h8000_0004;
    tick();
    int_req_i = 0;
    repeat (2) tick();
    ex_hold_req_i = 0;
    settle();
    chk("irq_ack", {31'h0, int_ack_o}, 32'h1);
    chk("irq_addr", jump_addr_o, 32'h8000_0004);
    adv();
    settle();
    chk("irq_once", {31'h0, int_ack_o}, 32'h0);
    adv();

    // Debug halt, drain, resume.
    resume_pc_i = 32'h40; dbg_halt_req_i = 1;
    tick();
    dbg_halt_req_i = 0;
    settle();
    chk("halt_run_quiet", {31'h0, flush_o}, 32'h0);
    adv();
    settle();
    chk("halt_flush_addr", jump_addr_o, 32'h40);
    chk("halt_flush_stall", {28'h0, stall_o}, 32'h1);
    adv();
    resume_pc_i = 32'h77;
    for (int i = 0; i < DC; i++) begin
      settle();
      chk("drain_stall", {28'h0, stall_o}, 32'hF);
      chk("drain_halted", {31'h0, dbg_halted_o}, 32'h0);
      adv();
    end
    settle();
    chk("halted_rise", {31'h0, dbg_halted_o}, 32'h1);
    adv();
    repeat (3) tick();
    dbg_resume_req_i = 1;
    settle();
    chk("resume_addr", jump_addr_o, 32'h40);
    chk("resume_stall", {28'h0, stall_o}, 32'h0);
    adv();
    dbg_resume_req_i = 0;
    settle();
    chk("halted_fall", {31'h0, dbg_halted_o}, 32'h0);
    adv();

    // Halt and interrupt pending together: halt first, interrupt after resume.
    int_req_i = 1; int_addr_i = 32'h0000_9000; dbg_halt_req_i = 1; resume_pc_i = 32'h500;
    tick();
    clear_inputs();
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      settle();
      chk("halt_before_irq", {31'h0, int_ack_o}, 32'h0);
      seen = dbg_halted_o;
      adv();
    end
    chk("halt_reached", {31'h0, seen}, 32'h1);
    dbg_resume_req_i = 1;
    tick();
    dbg_resume_req_i = 0;
    settle();
    chk("irq_after_resume", {31'h0, int_ack_o}, 32'h1);
    chk("irq_after_resume_addr", jump_addr_o, 32'h9000);
    adv();

    // Reset during DRAIN discards the pending interrupt.
    dbg_halt_req_i = 1;
    tick();
    dbg_halt_req_i = 0;
    tick();
    int_req_i = 1; int_addr_i = 32'hDEAD_0000;
    tick();
    int_req_i = 0;
    settle();
    chk("pre_reset_drain", {28'h0, stall_o}, 32'hF);
    jump_req_i = 1; jump_addr_i = 32'h3333_0000;
    rst_n = 0;
    #1;
    chk_all_zero("drain_reset");
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("no_stale_irq", {31'h0, int_ack_o}, 32'h0);
      adv();
    end

    // Random traffic.
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      jump_req_i = ($urandom_range(0, 99) < 15);
      jump_addr_i = $urandom;
      if (hold_left > 0) begin
        ex_hold_req_i = 1;
        hold_left--;
      end else if ($urandom_range(0, 99) < 12) begin
        ex_hold_req_i = 1;
        hold_left = $urandom_range(0, 3);
      end else begin
        ex_hold_req_i = 0;
      end
      int_req_i = ($urandom_range(0, 99) < 10);
      int_addr_i = $urandom;
      resume_pc_i = $urandom;
      dbg_halt_req_i = ($urandom_range(0, 99) < 5);
      dbg_resume_req_i = ($urandom_range(0, 99) < 20);
      tick();
    end
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control and scheduling unit for the core. Collects redirect, hold, interrupt and debug-halt requests. Generates the `STALL_WIDTH stall vector and the flush/jump pulses that drive the IF/ID and ID/EX pipeline registers and the PC register. A small state machine sequences debug halt entry, drain and resume. Interrupt requests are latched until they can be taken at a clean instruction boundary.

## Interface
- DRAIN_CYCLES, default 2: cycles the pipeline is held fully stalled after the halt flush, letting in-flight writeback retire before `dbg_halted_o` asserts. Legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- jump_req_i  input  1  EXU taken branch or jump, valid this cycle.
- jump_addr_i  input  32  EXU redirect target.
- ex_hold_req_i  input  1  multi-cycle op (divider) occupies EX; the pipeline must freeze.
- int_req_i  input  1  one-cycle interrupt request pulse from CLINT.
- int_addr_i  input  32  handler address, sampled together with `int_req_i`.
- resume_pc_i  input  32  PC of the oldest instruction that has not yet entered EX.
- dbg_halt_req_i  input  1  one-cycle halt request pulse from the debug module.
- dbg_resume_req_i  input  1  one-cycle resume request pulse from the debug module.
- stall_o  output  `STALL_WIDTH (4)  stall vector; bit `STALL_PC=0, `STALL_IF=1, `STALL_ID=2, `STALL_EX=3.
- flush_o  output  1  flushes the IF/ID and ID/EX registers (inserts NOPs).
- jump_o  output  1  PC register loads `jump_addr_o`.
- jump_addr_o  output  32  redirect target.
- int_ack_o  output  1  one-cycle pulse in the cycle the interrupt redirect is issued.
- dbg_halted_o  output  1  core halted (registered).

## Operation
- States: RUN, HALT_WAIT, DRAIN, HALTED. Reset state is RUN.
- Registered state:
  - `int_pend`, `int_addr_q`: `int_req_i` sets `int_pend` and captures `int_addr_i`. A new request while pending overwrites the address.
  - `halt_pend`: set by `dbg_halt_req_i`.
  - `resume_pc_q`.
  - drain counter, 4 bits.
- RUN, priority highest first:
  - `jump_req_i`: `flush_o`=1, `jump_o`=1, `jump_addr_o`=`jump_addr_i`, `stall_o`=0. Wins even if `ex_hold_req_i`=1.
  - `ex_hold_req_i`: `stall_o`=4'b1111. No flush.
  - `halt_pend`: go to HALT_WAIT (no outputs this cycle).
  - `int_pend`: `flush_o`=1, `jump_o`=1, `jump_addr_o`=`int_addr_q`, `int_ack_o`=1. Clear `int_pend`.
  - Otherwise all outputs 0.
- HALT_WAIT:
  - `jump_req_i` is served exactly as in RUN; stay in HALT_WAIT.
  - `ex_hold_req_i` gives `stall_o`=4'b1111; stay.
  - Otherwise: `flush_o`=1, `jump_o`=1, `jump_addr_o`=`resume_pc_i`, and `stall_o`=4'b0001 (PC held; the jump overrides the stall).
    - Capture `resume_pc_q`=`resume_pc_i`.
    - Clear `halt_pend`, load counter=DRAIN_CYCLES, go to DRAIN.
- DRAIN:
  - `stall_o`=4'b1111; decrement counter each cycle.
  - When the counter reaches 1, go to HALTED next edge, so `dbg_halted_o` rises exactly DRAIN_CYCLES cycles after the halt flush.
- HALTED:
  - `stall_o`=4'b1111, `dbg_halted_o`=1.
  - On `dbg_resume_req_i`: `flush_o`=1, `jump_o`=1, `jump_addr_o`=`resume_pc_q`, `stall_o`=0; go to RUN.
  - `dbg_halted_o` falls on the following edge.
- Interrupts are never taken outside RUN; they stay pending.
- `dbg_halt_req_i` in HALT_WAIT, DRAIN or HALTED is ignored.
- `dbg_resume_req_i` outside HALTED is ignored.

## Timing
- `stall_o`, `flush_o`, `jump_o`, `jump_addr_o` and `int_ack_o` are combinational from state and inputs (zero-cycle redirect). `dbg_halted_o` is a flop.
- Reset values and behaviour while `rst_n`=0:
  - all outputs 0, `jump_addr_o`=32'h0;
  - state RUN; `int_pend`, `halt_pend` and counter 0; `int_addr_q` and `resume_pc_q` 32'h0.
- Interrupt latency: taken in the first RUN cycle with no jump and no hold, at the earliest the cycle after `int_req_i`.
- Simultaneous events:
  - `int_req_i` in the same cycle as a take clears and re-sets `int_pend`; the new request wins.
  - `jump_req_i` together with a pending interrupt: the jump is served; the interrupt follows at the earliest next cycle.
  - Halt and interrupt both pending in RUN: halt wins; the interrupt is taken after resume.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately; pending requests are lost.

## Test plan
- Idle RUN, `jump_req_i`=1, `jump_addr_i`=32'h0000_0100 -> same cycle `flush_o`=1, `jump_o`=1, `jump_addr_o`=32'h100, `stall_o`=0.
- `ex_hold_req_i` high for 5 cycles -> `stall_o`=4'b1111 for exactly 5 cycles, `flush_o`=0. Assert `jump_req_i` in the hold's last cycle -> jump wins, `stall_o`=0.
- `int_req_i` pulse with addr 32'h8000_0004 during a 3-cycle hold -> `int_ack_o`, `jump_o`=1 and `jump_addr_o`=32'h8000_0004 exactly one cycle after the hold drops, once only.
- `dbg_halt_req_i` with `resume_pc_i`=32'h40 and DRAIN_CYCLES=2:
  - HALT_WAIT one cycle, then the flush/jump to 32'h40;
  - `dbg_halted_o`=1 two cycles later, `stall_o`=4'b1111 throughout.
  - Later `dbg_resume_req_i` -> jump to 32'h40, `dbg_halted_o` falls the next cycle.
- Interrupt and halt pending together -> halt completes first. After resume, `int_ack_o` fires the cycle after the resume jump.
- Assert `rst_n`=0 in DRAIN -> all outputs 0 asynchronously. After release, RUN; no stale interrupt is taken.
